// File: rtl/draw_sched_pkg.sv
// draw_sched_pkg: shared widths and FSM state encoding for the sprite draw scheduler.
package draw_sched_pkg;
   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int ADDR_W = 12;
   localparam int COL_W = 3;
   localparam int DIM_W = 6;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/sprite_walk_counter.sv
// sprite_walk_counter: row-major x/y offset and ROM address walker for one sprite.
module sprite_walk_counter
   import draw_sched_pkg::*;
(
   input  logic              clock_all,
   input  logic              reset_all,
   input  logic              clear,
   input  logic              step,
   input  logic [DIM_W-1:0]  wm1,
   input  logic [DIM_W-1:0]  hm1,
   output logic [DIM_W-1:0]  cx,
   output logic [DIM_W-1:0]  cy,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   assign last = (cx == wm1) && (cy == hm1);
   always_ff @(posedge clock_all) begin
      if (reset_all || clear) begin
         cx <= '0;
         cy <= '0;
         addr <= '0;
      end else if (step) begin
         addr <= addr + 1'b1;
         cx <= (cx == wm1) ? '0 : cx + 1'b1;
         cy <= (cx == wm1) ? cy + 1'b1 : cy;
      end
   end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: round-robin shared sprite walker driving one VGA plot port.
// Define SPRITE_TRANSPARENT_EN to suppress plots of KEY_COLOUR pixels.
module sprite_draw_scheduler
   import draw_sched_pkg::*;
#(
   parameter int               NREQ = 4,
   parameter logic [COL_W-1:0] KEY_COLOUR = 3'b000
)(
   input  logic                  clock_all,
   input  logic                  reset_all,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*X_W-1:0]   req_x,
   input  logic [NREQ*Y_W-1:0]   req_y,
   input  logic [NREQ*DIM_W-1:0] req_wm1,
   input  logic [NREQ*DIM_W-1:0] req_hm1,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic [2:0]            rom_sel,
   output logic [ADDR_W-1:0]     rom_address,
   input  logic [COL_W-1:0]      pix_colour,
   output logic                  plot,
   output logic [X_W-1:0]        out_x,
   output logic [Y_W-1:0]        out_y,
   output logic [COL_W-1:0]      out_colour,
   output logic                  busy
);
   localparam logic [3:0] NR = 4'(NREQ);
   state_t state;
   logic [2:0] rr_ptr, winner;
   logic [3:0] sum;
   logic [NREQ-1:0] rot;
   logic [X_W-1:0] base_x;
   logic [Y_W-1:0] base_y;
   logic [DIM_W-1:0] wm1, hm1, cx, cy;
   logic last, p_valid;
   logic [X_W-1:0] xs [8];
   logic [Y_W-1:0] ys [8];
   logic [DIM_W-1:0] ws [8];
   logic [DIM_W-1:0] hs [8];
   // Unused slots are tied off so the winner index can address all 8 entries.
   for (genvar g = 0; g < 8; g++) begin : g_slot
      if (g < NREQ) begin : g_used
         assign xs[g] = req_x[g*X_W +: X_W];
         assign ys[g] = req_y[g*Y_W +: Y_W];
         assign ws[g] = req_wm1[g*DIM_W +: DIM_W];
         assign hs[g] = req_hm1[g*DIM_W +: DIM_W];
      end else begin : g_tie
         assign xs[g] = '0;
         assign ys[g] = '0;
         assign ws[g] = '0;
         assign hs[g] = '0;
      end
   end
   // Rotate so bit 0 is rr_ptr, then the lowest set bit is the winner.
   always_comb begin
      rot = NREQ'({req, req} >> rr_ptr);
      winner = rr_ptr;
      sum = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr} + 4'(i);
         sum = (sum >= NR) ? sum - NR : sum;
         if (rot[i]) winner = sum[2:0];
      end
   end
   sprite_walk_counter u_walk (
      .clock_all(clock_all),
      .reset_all(reset_all),
      .clear(state == IDLE),
      .step(state == RUN && !last),
      .wm1(wm1),
      .hm1(hm1),
      .cx(cx),
      .cy(cy),
      .addr(rom_address),
      .last(last)
   );
   always_ff @(posedge clock_all) begin
      if (reset_all) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant <= '0;
         done <= '0;
         rom_sel <= '0;
         p_valid <= 1'b0;
         out_x <= '0;
         out_y <= '0;
         base_x <= '0;
         base_y <= '0;
         wm1 <= '0;
         hm1 <= '0;
      end else begin
         p_valid <= (state == RUN);
         out_x <= base_x + X_W'(cx);
         out_y <= base_y + Y_W'(cy);
         case (state)
            IDLE: if (|req) begin
               state <= RUN;
               grant <= NREQ'(1) << winner;
               rom_sel <= winner;
               rr_ptr <= ({1'b0, winner} == NR - 1'b1) ? '0 : winner + 1'b1;
               base_x <= xs[winner];
               base_y <= ys[winner];
               wm1 <= ws[winner];
               hm1 <= hs[winner];
            end
            RUN: if (last) state <= FLUSH;
            FLUSH: begin
               state <= DONE;
               done <= grant;
            end
            DONE: begin
               state <= IDLE;
               done <= '0;
               grant <= '0;
            end
         endcase
      end
   end
`ifdef SPRITE_TRANSPARENT_EN
   assign plot = p_valid && (pix_colour != KEY_COLOUR);
`else
   assign plot = p_valid;
`endif
   assign out_colour = pix_colour;
   assign busy = (state != IDLE);
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: table vectors, corner sequences and random jobs against a pixel-list model.
module tb_sprite_draw_scheduler;
   localparam int NREQ = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic [NREQ-1:0] req, grant, done;
   logic [NREQ*9-1:0] req_x;
   logic [NREQ*8-1:0] req_y;
   logic [NREQ*6-1:0] req_wm1, req_hm1;
   logic [2:0] rom_sel, pix_colour, out_colour;
   logic [11:0] rom_address;
   logic plot, busy;
   logic [8:0] out_x;
   logic [7:0] out_y;
   int checks = 0, errors = 0;

   sprite_draw_scheduler #(.NREQ(NREQ), .KEY_COLOUR(3'b000)) dut (
      .clock_all(clk), .reset_all(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .req_wm1(req_wm1), .req_hm1(req_hm1), .grant(grant), .done(done), .rom_sel(rom_sel),
      .rom_address(rom_address), .pix_colour(pix_colour), .plot(plot), .out_x(out_x),
      .out_y(out_y), .out_colour(out_colour), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {int idx, x, y, wm1, hm1, n, fx, fy, lx, ly, dc;} vec_t;

   task automatic set_slot(input int idx, input int x, input int y, input int wm1, input int hm1);
      req_x[idx*9 +: 9] = 9'(x);
      req_y[idx*8 +: 8] = 8'(y);
      req_wm1[idx*6 +: 6] = 6'(wm1);
      req_hm1[idx*6 +: 6] = 6'(hm1);
   endtask

   // Expected pixels come from a row-major list; cycle c shows pixel c-2.
   task automatic run_job(input int idx, input int x, input int y, input int wm1, input int hm1,
                          input bit alt, input int drop_at,
                          output int np, output int fx, output int fy, output int lx, output int ly, output int dc);
      int w, h, n;
      int ex[$], ey[$];
      logic [NREQ-1:0] oh;
      logic slot, ep;
      w = wm1 + 1;
      h = hm1 + 1;
      n = w * h;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            ex.push_back((x + c) % 512);
            ey.push_back((y + r) % 256);
         end
      oh = '0;
      oh[idx] = 1'b1;
      np = 0; fx = -1; fy = -1; lx = -1; ly = -1; dc = -1;
      set_slot(idx, x, y, wm1, hm1);
      req[idx] = 1'b1;
      pix_colour = 3'($urandom_range(1, 7));
      for (int c = 1; c <= n + 3; c++) begin
         @(negedge clk);
         slot = (c >= 2) && (c <= n + 1);
`ifdef SPRITE_TRANSPARENT_EN
         ep = slot && (pix_colour != 3'b000);
`else
         ep = slot;
`endif
         chk("plot", plot, ep);
         chk("busy", busy, c <= n + 2);
         chk("grant", grant, (c <= n + 2) ? oh : '0);
         chk("done", done, (c == n + 2) ? oh : '0);
         chk("out_colour", out_colour, pix_colour);
         if (c <= n + 2) chk("rom_sel", rom_sel, idx);
         if (c <= n) chk("rom_address", rom_address, c - 1);
         if (slot) begin
            chk("out_x", out_x, ex[c-2]);
            chk("out_y", out_y, ey[c-2]);
         end
         if (plot) begin
            if (np == 0) begin fx = out_x; fy = out_y; end
            lx = out_x; ly = out_y; np++;
         end
         if (done[idx] && dc < 0) dc = c;
         if (c == drop_at) begin
            req[idx] = 1'b0;
            set_slot(idx, ~x, ~y, 0, 0);
         end
         if (c == n + 2) req[idx] = 1'b0;
         pix_colour = (alt && c % 2 == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      end
   endtask

   task automatic wait_done(output logic [NREQ-1:0] d);
      d = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (|done) begin
            d = done;
            break;
         end
      end
   endtask

   initial begin
      vec_t vt[3];
      int np, fx, fy, lx, ly, dc, seen_done;
      logic [NREQ-1:0] d;
      vt[0] = '{0, 100, 40, 62, 55, 3528, 100, 40, 162, 95, 3530};
      vt[1] = '{1, 511, 255, 0, 0, 1, 511, 255, 511, 255, 3};
      vt[2] = '{3, 510, 0, 3, 1, 8, 510, 0, 1, 1, 10};
      rst = 1'b1; req = '0; req_x = '0; req_y = '0; req_wm1 = '0; req_hm1 = '0; pix_colour = '0;
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rom_address", rom_address, 0);
      chk("rst_rom_sel", rom_sel, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
         run_job(vt[v].idx, vt[v].x, vt[v].y, vt[v].wm1, vt[v].hm1, 1'b0, -1, np, fx, fy, lx, ly, dc);
         chk("vec_plots", np, vt[v].n);
         chk("vec_first_x", fx, vt[v].fx);
         chk("vec_first_y", fy, vt[v].fy);
         chk("vec_last_x", lx, vt[v].lx);
         chk("vec_last_y", ly, vt[v].ly);
         chk("vec_done_cycle", dc, vt[v].dc);
      end
      // Round robin from a fresh rr pointer of 0.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_slot(i, 10 * i, 5 * i, 1, 0);
      req = 4'b1010;
      @(negedge clk);
      chk("rr_grant1", grant, 4'b0010);
      chk("rr_sel1", rom_sel, 1);
      wait_done(d);
      chk("rr_done1", d, 4'b0010);
      req[1] = 1'b0;
      @(negedge clk);
      chk("rr_gap", grant, 4'b0000);
      @(negedge clk);
      chk("rr_grant2", grant, 4'b1000);
      chk("rr_sel2", rom_sel, 3);
      wait_done(d);
      chk("rr_done2", d, 4'b1000);
      req = 4'b0101;
      repeat (2) @(negedge clk);
      chk("rr_grant3", grant, 4'b0001);
      wait_done(d);
      chk("rr_done3", d, 4'b0001);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rr_grant4", grant, 4'b0100);
      wait_done(d);
      chk("rr_done4", d, 4'b0100);
      req = '0;
      @(negedge clk);
      // Requester drops req and changes its origin mid-job.
      run_job(2, 30, 20, 3, 3, 1'b0, 5, np, fx, fy, lx, ly, dc);
      chk("drop_done_cycle", dc, 18);
      // Reset in cycle 500 of a large job.
      set_slot(0, 7, 9, 63, 63);
      req[0] = 1'b1;
      seen_done = 0;
      for (int c = 1; c <= 500; c++) begin
         @(negedge clk);
         if (|done) seen_done++;
      end
      chk("mid_busy", busy, 1);
      chk("mid_rom_address", rom_address, 499);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_plot", plot, 0);
      chk("abort_grant", grant, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rom_address", rom_address, 0);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      if (|done) seen_done++;
      chk("abort_no_done", seen_done, 0);
      run_job(0, 200, 100, 2, 2, 1'b0, -1, np, fx, fy, lx, ly, dc);
      chk("restart_done_cycle", dc, 11);
      // Alternate key-coloured pixels.
      run_job(1, 5, 5, 7, 3, 1'b1, -1, np, fx, fy, lx, ly, dc);
      chk("alt_done_cycle", dc, 34);
`ifdef SPRITE_TRANSPARENT_EN
      chk("alt_plots", np, 16);
`else
      chk("alt_plots", np, 32);
`endif
      for (int r = 0; r < 6; r++) begin
         int ri, rw, rh;
         ri = $urandom_range(0, NREQ - 1);
         rw = $urandom_range(0, 15);
         rh = $urandom_range(0, 15);
         run_job(ri, $urandom_range(0, 511), $urandom_range(0, 255), rw, rh, 1'b0, -1, np, fx, fy, lx, ly, dc);
         chk("rand_done_cycle", dc, (rw + 1) * (rh + 1) + 2);
         chk("rand_plots", np, (rw + 1) * (rh + 1));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Shares a single sprite pixel-walk engine and the single VGA plot port among `NREQ` sprite requesters, such as the thunder, Pokémon and HP-bar drawers. The block:
- arbitrates round-robin between pending requests;
- latches the winner's screen origin and sprite size;
- walks the sprite ROM address and x/y offsets;
- compensates the one-cycle ROM read latency and drives plot, x, y and colour to the VGA adapter.

It sits between the battle-screen FSM and the VGA adapter, replacing per-sprite counters.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `KEY_COLOUR`, 3'b000, transparent colour (used only with `SPRITE_TRANSPARENT_EN`)

Ports:
- `clock_all` in 1: single clock; all state changes on its rising edge
- `reset_all` in 1: reset, synchronous, active-high
- `req` in `NREQ`: per-requester draw request; level, held until `done`
- `req_x` in `NREQ`*9: flattened origin x; slice i = [9i+8:9i]
- `req_y` in `NREQ`*8: flattened origin y
- `req_wm1` in `NREQ`*6: sprite width minus 1
- `req_hm1` in `NREQ`*6: sprite height minus 1
- `grant` out `NREQ`: one-hot, high for the whole job
- `done` out `NREQ`: one-cycle pulse to the finished requester
- `rom_sel` out 3: index of the granted requester; the top level muxes ROM q with it
- `rom_address` out 12: sprite ROM read address
- `pix_colour` in 3: ROM q, valid one cycle after `rom_address`
- `plot` out 1: VGA write enable
- `out_x` out 9: VGA x
- `out_y` out 8: VGA y
- `out_colour` out 3: VGA colour
- `busy` out 1: state is not IDLE

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - If any `req` bit is high, pick the first set bit at or after `rr_ptr` (wrapping).
  - Set `grant`, `rom_sel` and `rr_ptr` = winner+1 (mod `NREQ`).
  - Latch the winner's x, y, wm1 and hm1, and clear cx, cy and addr. Next state is RUN.
- RUN:
  - `rom_address` = addr.
  - Each cycle: addr+1 and cx+1. When cx==wm1, set cx=0 and cy+1.
  - When cx==wm1 and cy==hm1, go to FLUSH. Counters hold at that point.
- Pixel pipeline, one register stage:
  - p_valid = (state==RUN).
  - p_x = base_x+cx, truncated to 9 bits (wraps mod 512).
  - p_y = base_y+cy, truncated to 8 bits (wraps mod 256).
  - `plot` = p_valid; `out_x` = p_x; `out_y` = p_y; `out_colour` = `pix_colour` passed through combinationally.
- FLUSH: one cycle in which the last pixel is plotted. Next state is DONE.
- DONE:
  - `done[winner]` = 1 for this cycle only.
  - `grant` clears at the next edge. Next state is IDLE.
- Request inputs are sampled only in IDLE.
  - Dropping `req` mid-job has no effect; the job completes.
  - Changing `req_x` mid-job has no effect.
- Pixel count per job is (wm1+1)*(hm1+1); the largest is 64*64 = 4096. addr wraps at 12 bits exactly at 4096.
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `done` 0, `plot` 0, `busy` 0, `rom_address` 0, `rom_sel` 0, `out_x` 0, `out_y` 0.
- Reset mid-job: all outputs take their reset values at the next edge. No `done` is issued for the aborted job.

## Timing
- `req` high in IDLE at edge 0 → `grant` and `busy` high from edge 1; `rom_address`=0 during cycle 1.
- First `plot` is in cycle 2 with `out_x`=x and `out_y`=y.
- For N pixels: RUN covers cycles 1..N, FLUSH is N+1, `done` is high in N+2, IDLE in N+3, and the next `grant` no earlier than N+4.
- Throughput is 1 pixel/cycle. The gap between jobs is 3 idle plot cycles.
- Simultaneous requests are served in round-robin order with no starvation. Each requester waits at most `NREQ`-1 jobs.

## Configuration
- `SPRITE_TRANSPARENT_EN` defined: `plot` = p_valid && (`pix_colour` != `KEY_COLOUR`). Timing and `done` are unchanged.
- Not defined: every pixel is plotted and `KEY_COLOUR` is ignored.

## Structure
- Package `draw_sched_pkg` holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - constants X_W=9, Y_W=8, ADDR_W=12, COL_W=3, DIM_W=6.
- Sub-module `sprite_walk_counter`:
  - inputs: clear, step, wm1, hm1;
  - outputs: cx, cy, addr, last.
- Arbiter and pipeline register live in the top.

## Test plan
- 63x56 sprite (wm1=62, hm1=55) at (100,40) from req[0]:
  - 3528 plots, first at (100,40), last at (162,95);
  - `done[0]` in cycle 3530;
  - `rom_address` runs 0..3527.
- req[1] and req[3] asserted together with `rr_ptr`=0:
  - req[1] served first, then req[3];
  - `rr_ptr`=0 after the second grant.
- 1x1 sprite at (511,255) with origin wrap:
  - one plot at (511,255);
  - 4x2 sprite at (510,0) gives x sequence 510,511,0,1.
- `reset_all` pulsed in cycle 500 of a job:
  - `plot`, `grant` and `busy` are 0 the next cycle;
  - no `done`; a new request restarts at address 0.
- req[2] dropped mid-job: the job completes and `done[2]` still pulses.
- `SPRITE_TRANSPARENT_EN` with `pix_colour`=000 on alternate pixels: `plot` is low on those pixels and the `done` cycle is unchanged.
